// File: rtl/instr_loader_if.sv
// Handshake and memory-write bundle between a byte source, the program loader
// and the instruction memory / core hold logic.
interface instr_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic        cpu_hold;
  logic        done;
  logic        err;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_data, cpu_hold, done, err
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_data, cpu_hold, done, err
  );
endinterface

// File: rtl/instr_loader.sv
// Byte-serial program loader: takes a length-prefixed little-endian byte stream,
// writes 32-bit words to instruction memory and holds the core until complete.
module instr_loader #(
  parameter int MAX_WORDS = 64
) (
  input  logic          clk,
  input  logic          rst,
  instr_loader_if.slave bus
);

  localparam logic [7:0] MAX_COUNT = 8'(MAX_WORDS);

  typedef enum logic [2:0] {HDR, LOAD, WRITE, DONE, ERR} state_t;

  state_t      state;
  logic [7:0]  word_count;
  logic [6:0]  word_idx;
  logic [1:0]  byte_cnt;
  logic [31:0] assembly;
  logic        accept;

  assign bus.byte_ready = (state == HDR) || (state == LOAD);
  assign accept         = bus.byte_valid && bus.byte_ready;

  // The write strobe, address and data are registered on the 4th byte so the
  // strobe occupies exactly the WRITE cycle; the 4th byte goes straight into
  // the word rather than waiting a cycle in the assembly register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= HDR;
      word_count    <= 8'd0;
      word_idx      <= 7'd0;
      byte_cnt      <= 2'd0;
      assembly      <= 32'd0;
      bus.imem_we   <= 1'b0;
      bus.imem_addr <= 8'd0;
      bus.imem_data <= 32'd0;
      bus.cpu_hold  <= 1'b1;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      bus.imem_we <= 1'b0;
      case (state)
        HDR: begin
          if (accept) begin
            if (bus.byte_data == 8'd0) begin
              state        <= DONE;
              bus.cpu_hold <= 1'b0;
              bus.done     <= 1'b1;
            end else if (bus.byte_data > MAX_COUNT) begin
              state   <= ERR;
              bus.err <= 1'b1;
            end else begin
              word_count <= bus.byte_data;
              word_idx   <= 7'd0;
              byte_cnt   <= 2'd0;
              state      <= LOAD;
            end
          end
        end

        LOAD: begin
          if (accept) begin
            assembly[{byte_cnt, 3'b000} +: 8] <= bus.byte_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state         <= WRITE;
              bus.imem_we   <= 1'b1;
              bus.imem_addr <= {word_idx[5:0], 2'b00};
              bus.imem_data <= {bus.byte_data, assembly[23:0]};
            end
          end
        end

        WRITE: begin
          if (({1'b0, word_idx} + 8'd1) == word_count) begin
            state        <= DONE;
            bus.cpu_hold <= 1'b0;
            bus.done     <= 1'b1;
          end else begin
            word_idx <= word_idx + 7'd1;
            state    <= LOAD;
          end
        end

        DONE, ERR: begin
          state <= state;
        end

        default: begin
          state <= HDR;
        end
      endcase
    end
  end

endmodule
